score_tracker: RTL and testbench

Score and combo accumulator sitting directly downstream of the per-lane arrow dropper instances. It consumes every dropper's `score` level, detects new hits, and tracks combo, a combo-based multiplier and the running score over one timed song. It exposes binary and BCD score for the HUD/hex-display stage, and runs the Idle/Playing/Done game flow from the same keycodes the droppers use.

---
 rtl/score_tracker.sv | 127 ++++++++++++
 tb/tb_score_tracker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/score_tracker.sv
// Score/combo accumulator behind the arrow droppers: detects rising score edges,
// tracks combo, multiplier and running score over one timed song, exposes binary + BCD.
module score_tracker #(
  parameter int NUM_LANES      = 48,
  parameter int POINTS_PER_HIT = 10,
  parameter int COMBO_WINDOW   = 120,
  parameter int GAME_FRAMES    = 3600
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode,
  input  logic [NUM_LANES-1:0] score_vec,
  output logic [13:0]          score_bin,
  output logic [15:0]          score_bcd,
  output logic [9:0]           hit_count,
  output logic [7:0]           combo,
  output logic [7:0]           max_combo,
  output logic                 playing,
  output logic                 game_over
);

  localparam int NW = $clog2(NUM_LANES + 1);
  localparam int GW = $clog2(COMBO_WINDOW + 2);
  localparam logic [GW-1:0] GAP_SAT    = GW'(COMBO_WINDOW + 1);
  localparam logic [GW-1:0] GAP_MAX    = GW'(COMBO_WINDOW);
  localparam logic [11:0]   LAST_FRAME = 12'(GAME_FRAMES - 1);
  localparam logic [7:0]    KEY_START  = 8'h2c;
  localparam logic [7:0]    KEY_ABORT  = 8'h01;

  typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;

  state_t               state, state_next;
  logic [NUM_LANES-1:0] score_prev, new_hits;
  logic [11:0]          frame_cnt;
  logic [GW-1:0]        gap;
  logic [NW-1:0]        n;
  logic [15:0]          combo_sum, add, hit_sum;
  logic [7:0]           combo_new;
  logic [2:0]           mult;
  logic [16:0]          score_sum;
  logic [13:0]          score_next;
  logic [9:0]           hit_next;
  logic                 start;

  function automatic logic [15:0] to_bcd(input logic [13:0] v);
    return {4'(v / 14'd1000), 4'((v / 14'd100) % 14'd10),
            4'((v / 14'd10) % 14'd10), 4'(v % 14'd10)};
  endfunction

  // Abort wins over both the start key and the song timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (keycode == KEY_START) state_next = PLAYING;
      PLAYING: if (frame_cnt == LAST_FRAME) state_next = DONE;
      default: state_next = state;
    endcase
    if (keycode == KEY_ABORT) state_next = IDLE;
  end

  assign start     = (state == IDLE) && (state_next == PLAYING);
  assign playing   = (state == PLAYING);
  assign game_over = (state == DONE);

  always_comb begin
    new_hits = score_vec & ~score_prev;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++) n = n + NW'(new_hits[i]);
  end

  always_comb begin
    if (gap <= GAP_MAX && combo != 8'd0) combo_sum = 16'(combo) + 16'(n);
    else                                 combo_sum = 16'(n);
    combo_new  = (combo_sum > 16'd255) ? 8'hff : combo_sum[7:0];
    mult       = (combo_new >= 8'd30) ? 3'd4 : 3'd1 + 3'(combo_new / 8'd10);
    add        = 16'(n) * 16'(POINTS_PER_HIT) * 16'(mult);
    score_sum  = 17'(score_bin) + 17'(add);
    score_next = (score_sum > 17'd9999) ? 14'd9999 : score_sum[13:0];
    hit_sum    = 16'(hit_count) + 16'(n);
    hit_next   = (hit_sum > 16'd1023) ? 10'h3ff : hit_sum[9:0];
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      score_prev <= '0;
      score_bcd  <= '0;
    end else begin
      score_prev <= score_vec;
      score_bcd  <= to_bcd(score_bin);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      score_bin <= '0;
      hit_count <= '0;
      combo     <= '0;
      max_combo <= '0;
      frame_cnt <= '0;
      gap       <= '0;
    end else if (start) begin
      score_bin <= '0;
      hit_count <= '0;
      combo     <= '0;
      max_combo <= '0;
      frame_cnt <= '0;
      gap       <= GAP_SAT;
    end else if (state == PLAYING) begin
      frame_cnt <= frame_cnt + 12'd1;
      if (n != '0) begin
        gap       <= '0;
        combo     <= combo_new;
        score_bin <= score_next;
        hit_count <= hit_next;
        if (combo_new > max_combo) max_combo <= combo_new;
      end else if (gap < GAP_SAT) begin
        gap <= gap + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Randomized + directed bench for score_tracker against a frame-indexed reference model.
module tb_score_tracker;
  localparam int NL  = 48;
  localparam int PPH = 10;
  localparam int CW  = 120;
  localparam int GF  = 3600;

  logic          frame_clk = 1'b0;
  logic          Reset = 1'b1;
  logic [7:0]    keycode = 8'h00;
  logic [NL-1:0] score_vec = '0;
  logic [13:0]   score_bin;
  logic [15:0]   score_bcd;
  logic [9:0]    hit_count;
  logic [7:0]    combo, max_combo;
  logic          playing, game_over;

  score_tracker #(.NUM_LANES(NL), .POINTS_PER_HIT(PPH), .COMBO_WINDOW(CW), .GAME_FRAMES(GF)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .score_vec(score_vec),
    .score_bin(score_bin), .score_bcd(score_bcd), .hit_count(hit_count), .combo(combo),
    .max_combo(max_combo), .playing(playing), .game_over(game_over));

  always #5 frame_clk = ~frame_clk;

  int n_chk = 0, n_fail = 0;

  // reference model: state 0 idle, 1 playing, 2 done; hits remembered by frame index
  int m_state, m_score, m_hits, m_combo, m_max, m_frame, m_last, m_bcd;
  logic [NL-1:0] m_prev;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int bcd_of(input int s);
    return ((s / 1000) << 12) | (((s / 100) % 10) << 8) | (((s / 10) % 10) << 4) | (s % 10);
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hits = 0; m_combo = 0; m_max = 0;
    m_frame = 0; m_last = -100000; m_bcd = 0; m_prev = '0;
  endtask

  task automatic model_step(input logic [7:0] kc, input logic [NL-1:0] v);
    int n, cn, mult;
    m_bcd = bcd_of(m_score);
    if (m_state == 1) begin
      n = $countones(v & ~m_prev);
      if (n > 0) begin
        if (m_combo > 0 && (m_frame - m_last - 1) <= CW) cn = m_combo + n;
        else cn = n;
        if (cn > 255) cn = 255;
        if (cn > m_max) m_max = cn;
        mult = (cn >= 30) ? 4 : 1 + cn / 10;
        m_score = m_score + n * PPH * mult;
        if (m_score > 9999) m_score = 9999;
        m_hits = m_hits + n;
        if (m_hits > 1023) m_hits = 1023;
        m_combo = cn;
        m_last = m_frame;
      end
    end
    if (kc == 8'h01) begin
      m_state = 0;
    end else if (m_state == 0 && kc == 8'h2c) begin
      m_state = 1; m_score = 0; m_hits = 0; m_combo = 0; m_max = 0;
      m_frame = 0; m_last = -100000;
    end else if (m_state == 1) begin
      if (m_frame == GF - 1) m_state = 2;
      m_frame++;
    end
    m_prev = v;
  endtask

  task automatic check_all();
    chk("score_bin", int'(score_bin), m_score);
    chk("score_bcd", int'(score_bcd), m_bcd);
    chk("hit_count", int'(hit_count), m_hits);
    chk("combo", int'(combo), m_combo);
    chk("max_combo", int'(max_combo), m_max);
    chk("playing", int'(playing), int'(m_state == 1));
    chk("game_over", int'(game_over), int'(m_state == 2));
  endtask

  task automatic step(input logic [7:0] kc, input logic [NL-1:0] v);
    keycode = kc;
    score_vec = v;
    @(posedge frame_clk);
    model_step(kc, v);
    #1 check_all();
  endtask

  function automatic logic [NL-1:0] rnd_vec(input int sparse);
    logic [NL-1:0] r;
    r = NL'({$urandom(), $urandom()});
    for (int k = 0; k < sparse; k++) r = r & NL'({$urandom(), $urandom()});
    return r;
  endfunction

  task automatic restart();
    step(8'h01, '0);
    step(8'h2c, '0);
  endtask

  initial begin
    logic [NL-1:0] v;
    int r;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1 check_all();
    Reset = 1'b0;
    step(8'h00, '0);

    // single hit on lane 3
    step(8'h2c, '0);
    step(8'h00, NL'(8));
    chk("hit1_count", int'(hit_count), 1);
    chk("hit1_combo", int'(combo), 1);
    chk("hit1_score", int'(score_bin), 10);
    step(8'h00, '0);
    chk("hit1_bcd", int'(score_bcd), 16'h0010);

    // twelve simultaneous lanes from combo 0
    restart();
    step(8'h00, NL'(12'hfff));
    chk("twelve_combo", int'(combo), 12);
    chk("twelve_score", int'(score_bin), 240);
    chk("twelve_max", int'(max_combo), 12);

    // combo window: 121 empty frames resets, 120 extends
    restart();
    step(8'h00, NL'(1));
    repeat (121) step(8'h00, '0);
    step(8'h00, NL'(1));
    chk("gap121_combo", int'(combo), 1);
    repeat (120) step(8'h00, '0);
    step(8'h00, NL'(1));
    chk("gap120_combo", int'(combo), 2);

    // lane held across the start is not a hit
    step(8'h01, NL'(1));
    step(8'h2c, NL'(1));
    step(8'h00, NL'(1));
    step(8'h00, NL'(1));
    chk("held_hits", int'(hit_count), 0);

    // saturate the score
    restart();
    for (int i = 0; i < 2000 && m_score < 9999; i++) step(8'h00, (i % 2 == 0) ? rnd_vec(0) : '0);
    chk("sat_score", int'(score_bin), 9999);
    step(8'h00, '0);
    chk("sat_bcd", int'(score_bcd), 16'h9999);

    // run out the song, then edges in Done are ignored
    restart();
    for (int i = 0; i < GF + 100 && m_state == 1; i++) step(8'h00, rnd_vec(3));
    chk("song_done", int'(game_over), 1);
    r = int'(hit_count);
    for (int i = 0; i < 10; i++) step(8'h00, (i % 2 == 0) ? rnd_vec(0) : '0);
    chk("done_hold", int'(hit_count), r);
    step(8'h01, '0);
    chk("abort_idle", int'(playing | game_over), 0);
    step(8'h2c, '0);
    chk("start_clear", int'(score_bin) + int'(hit_count) + int'(max_combo), 0);

    // random keycodes and lanes
    for (int i = 0; i < 6000; i++) begin
      r = $urandom_range(0, 599);
      v = ($urandom_range(0, 2) == 0) ? rnd_vec($urandom_range(0, 4)) : '0;
      if (r == 0)      step(8'h01, v);
      else if (r < 20) step(8'h2c, v);
      else if (r < 25) step(8'($urandom_range(0, 255)), v);
      else             step(8'h00, v);
    end

    // asynchronous reset mid-game
    restart();
    for (int i = 0; i < 40; i++) step(8'h00, (i % 2 == 0) ? rnd_vec(2) : '0);
    chk("pre_reset_nz", int'(score_bin != 0), 1);
    #2 Reset = 1'b1;
    model_reset();
    #1 check_all();
    #1 Reset = 1'b0;
    step(8'h00, '0);
    chk("post_reset_idle", int'(playing), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
